stream_mac: RTL and testbench

Parametrised streaming multiply-accumulate unit for the convolution datapath. It consumes a packet of operand pairs (`i_TDATA`, `k_TDATA`) over an AXI-Stream-style handshake and forms `bias + Σ i·k` in a wide accumulator. On `TLAST` it shifts, rounds and saturates the sum and emits one result beat. It supersedes the fixed 8-bit, free-running MAC with packet framing, backpressure, signed mode, chaining and output formatting.

---
 rtl/stream_mac.sv | 235 +++++++++++++++++++++++
 tb/tb_stream_mac.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mac.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mac
//  Purpose  : Streaming multiply-accumulate over packets of operand pairs.
//             Each accepted beat forms i*k (stage 1), which is added into a
//             wide accumulator (stage 2). The first beat of a packet seeds the
//             accumulator from the bias or from the previous packet's final
//             sum (chaining). After the last beat, the sum is rounded,
//             shifted, optionally saturated and presented as one result beat.
//  Ports    : clk, reset            - clock (rising edge), async active-high reset
//             i_TDATA/k_TDATA       - activation / weight operands
//             i_TVALID/i_TLAST      - operand pair valid / last pair of packet
//             i_TREADY              - unit accepts a pair
//             b_TDATA, b_enable     - bias and seed select, taken on first beat
//             o_TDATA/o_TUSER       - formatted result / result was clipped
//             o_TVALID/o_TREADY     - result handshake
//  Revision : 1.0 - initial release
// ============================================================================
module stream_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 0,
    parameter int SIGNED = 0,
    parameter int ROUND  = 0,
    parameter int SAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_TDATA,
    input  logic [DATA_W-1:0] k_TDATA,
    input  logic              i_TVALID,
    input  logic              i_TLAST,
    output logic              i_TREADY,
    input  logic [ACC_W-1:0]  b_TDATA,
    input  logic              b_enable,
    output logic [OUT_W-1:0]  o_TDATA,
    output logic              o_TVALID,
    input  logic              o_TREADY,
    output logic              o_TUSER
);

    // Formatting works two bits wider than the accumulator so that rounding
    // of an unsigned near-full-scale sum cannot wrap.
    localparam int   c_W    = ACC_W + 2;
    localparam logic c_SGN  = (SIGNED != 0);
    localparam logic c_SAT  = (SAT != 0);
    localparam int   c_RSH  = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [c_W-1:0] c_ONE  = c_W'(1);
    localparam logic signed [c_W-1:0] c_RND  = ((ROUND != 0) && (SHIFT > 0)) ?
                                               (c_ONE <<< c_RSH) : '0;
    localparam logic signed [c_W-1:0] c_OMAX = c_SGN ?
                                               (c_ONE <<< (OUT_W - 1)) - c_ONE :
                                               (c_ONE <<< OUT_W) - c_ONE;
    localparam logic signed [c_W-1:0] c_OMIN = c_SGN ?
                                               -(c_ONE <<< (OUT_W - 1)) : '0;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_q,   state_d;
    logic                  in_pkt_q,  in_pkt_d;   // a non-last beat has been taken
    logic [2*DATA_W-1:0]   prod_q,    prod_d;
    logic                  p_valid_q, p_valid_d;
    logic                  p_first_q, p_first_d;
    logic                  p_last_q,  p_last_d;
    logic [ACC_W-1:0]      p_bias_q,  p_bias_d;
    logic                  p_ben_q,   p_ben_d;
    logic [ACC_W-1:0]      acc_q,     acc_d;
    logic                  i_tready_q, i_tready_d;
    logic                  o_tvalid_q, o_tvalid_d;
    logic [OUT_W-1:0]      o_tdata_q,  o_tdata_d;
    logic                  o_tuser_q,  o_tuser_d;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic                  w_beat;
    logic [2*DATA_W-1:0]   w_i_ext;
    logic [2*DATA_W-1:0]   w_k_ext;
    logic [ACC_W-1:0]      w_prod_ext;
    logic signed [c_W-1:0] w_acc_x;
    logic signed [c_W-1:0] w_rnd;
    logic signed [c_W-1:0] w_shf;
    logic [OUT_W-1:0]      w_fmt;
    logic                  w_clip;

    assign w_beat = i_TVALID & i_tready_q;

    // Operands widened to the product width first; the low 2*DATA_W bits of
    // the widened multiply are the exact signed or unsigned product.
    assign w_i_ext = {{DATA_W{c_SGN & i_TDATA[DATA_W-1]}}, i_TDATA};
    assign w_k_ext = {{DATA_W{c_SGN & k_TDATA[DATA_W-1]}}, k_TDATA};

    generate
        if (SIGNED != 0) begin : g_sext
            assign w_prod_ext = ACC_W'($signed(prod_q));
        end else begin : g_zext
            assign w_prod_ext = ACC_W'(prod_q);
        end
    endgenerate

    // Result formatting from the settled accumulator.
    assign w_acc_x = {{2{c_SGN & acc_q[ACC_W-1]}}, acc_q};
    assign w_rnd   = w_acc_x + c_RND;
    assign w_shf   = w_rnd >>> SHIFT;

    always_comb begin
        w_fmt  = w_shf[OUT_W-1:0];
        w_clip = 1'b0;
        if (c_SAT) begin
            if (w_shf > c_OMAX) begin
                w_fmt  = c_OMAX[OUT_W-1:0];
                w_clip = 1'b1;
            end else if (w_shf < c_OMIN) begin
                w_fmt  = c_OMIN[OUT_W-1:0];
                w_clip = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        in_pkt_d   = in_pkt_q;
        prod_d     = prod_q;
        p_valid_d  = w_beat;
        p_first_d  = p_first_q;
        p_last_d   = p_last_q;
        p_bias_d   = p_bias_q;
        p_ben_d    = p_ben_q;
        acc_d      = acc_q;
        o_tdata_d  = o_tdata_q;
        o_tuser_d  = o_tuser_q;

        // Stage 1: product and packet framing.
        if (w_beat) begin
            prod_d    = w_i_ext * w_k_ext;
            p_first_d = ~in_pkt_q;
            p_last_d  = i_TLAST;
            p_bias_d  = b_TDATA;
            p_ben_d   = b_enable;
            in_pkt_d  = ~i_TLAST;
        end

        // Stage 2: accumulate; a first beat without bias continues from the
        // retained sum of the previous packet.
        if (p_valid_q) begin
            if (p_first_q && p_ben_q) begin
                acc_d = p_bias_q + w_prod_ext;
            end else begin
                acc_d = acc_q + w_prod_ext;
            end
        end

        // The FSM leaves RUN once the last product reaches stage 2, so DRAIN
        // is the single cycle in which the final sum sits in acc_q.
        case (state_q)
            S_RUN: begin
                if (p_valid_q && p_last_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d   = S_OUT;
                o_tdata_d = w_fmt;
                o_tuser_d = w_clip;
            end
            S_OUT: begin
                if (o_TREADY) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        // Input closes on the edge that takes the last beat and stays closed
        // until the result has been handed off.
        i_tready_d = (state_d == S_RUN) && !(w_beat && i_TLAST);
        o_tvalid_d = (state_d == S_OUT);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_RUN;
            in_pkt_q   <= 1'b0;
            prod_q     <= '0;
            p_valid_q  <= 1'b0;
            p_first_q  <= 1'b0;
            p_last_q   <= 1'b0;
            p_bias_q   <= '0;
            p_ben_q    <= 1'b0;
            acc_q      <= '0;
            i_tready_q <= 1'b1;
            o_tvalid_q <= 1'b0;
            o_tdata_q  <= '0;
            o_tuser_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_pkt_q   <= in_pkt_d;
            prod_q     <= prod_d;
            p_valid_q  <= p_valid_d;
            p_first_q  <= p_first_d;
            p_last_q   <= p_last_d;
            p_bias_q   <= p_bias_d;
            p_ben_q    <= p_ben_d;
            acc_q      <= acc_d;
            i_tready_q <= i_tready_d;
            o_tvalid_q <= o_tvalid_d;
            o_tdata_q  <= o_tdata_d;
            o_tuser_q  <= o_tuser_d;
        end
    end

    assign i_TREADY = i_tready_q;
    assign o_TVALID = o_tvalid_q;
    assign o_TDATA  = o_tdata_q;
    assign o_TUSER  = o_tuser_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_mac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_mac
//  Purpose  : Scoreboard bench for stream_mac. Four instances: A (unsigned,
//             saturating), B (unsigned, truncating), C (signed, saturating),
//             D (signed, SHIFT=8 with rounding). A/B share the "u" input bus,
//             C/D share the "s" bus. Expected results are queued when a packet
//             is issued and popped by a monitor on every output handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mac;

    logic clk = 1'b0;
    logic reset;
    logic o_rdy;
    always #5 clk = ~clk;

    logic [7:0]  u_i, u_k, s_i, s_k;
    logic        u_v, u_l, u_ben, s_v, s_l, s_ben;
    logic [23:0] u_b, s_b;

    logic       a_rdy, b_rdy, c_rdy, d_rdy;
    logic [7:0] a_d, b_d, c_d, d_d;
    logic       a_v, b_v, c_v, d_v;
    logic       a_u, b_u, c_u, d_u;

    stream_mac u_a (
        .clk(clk), .reset(reset), .i_TDATA(u_i), .k_TDATA(u_k), .i_TVALID(u_v),
        .i_TLAST(u_l), .i_TREADY(a_rdy), .b_TDATA(u_b), .b_enable(u_ben),
        .o_TDATA(a_d), .o_TVALID(a_v), .o_TREADY(o_rdy), .o_TUSER(a_u));

    stream_mac #(.SAT(0)) u_b_dut (
        .clk(clk), .reset(reset), .i_TDATA(u_i), .k_TDATA(u_k), .i_TVALID(u_v),
        .i_TLAST(u_l), .i_TREADY(b_rdy), .b_TDATA(u_b), .b_enable(u_ben),
        .o_TDATA(b_d), .o_TVALID(b_v), .o_TREADY(o_rdy), .o_TUSER(b_u));

    stream_mac #(.SIGNED(1)) u_c (
        .clk(clk), .reset(reset), .i_TDATA(s_i), .k_TDATA(s_k), .i_TVALID(s_v),
        .i_TLAST(s_l), .i_TREADY(c_rdy), .b_TDATA(s_b), .b_enable(s_ben),
        .o_TDATA(c_d), .o_TVALID(c_v), .o_TREADY(o_rdy), .o_TUSER(c_u));

    stream_mac #(.SIGNED(1), .SHIFT(8), .ROUND(1)) u_d (
        .clk(clk), .reset(reset), .i_TDATA(s_i), .k_TDATA(s_k), .i_TVALID(s_v),
        .i_TLAST(s_l), .i_TREADY(d_rdy), .b_TDATA(s_b), .b_enable(s_ben),
        .o_TDATA(d_d), .o_TVALID(d_v), .o_TREADY(o_rdy), .o_TUSER(d_u));

    // Queue entries are {user, data}.
    logic [8:0] qa[$], qb[$], qc[$], qd[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    task automatic cmp(input string nm, input logic [8:0] e, input logic [7:0] d, input logic u);
        chk({nm, " o_TDATA"}, 32'(d), 32'(e[7:0]));
        chk({nm, " o_TUSER"}, 32'(u), 32'(e[8]));
    endtask

    // Monitor: one comparison pair per output handshake.
    always @(negedge clk) begin
        if (!reset && o_rdy) begin
            if (a_v) begin
                if (qa.size() == 0) fail_now("A unexpected result");
                else cmp("A", qa.pop_front(), a_d, a_u);
            end
            if (b_v) begin
                if (qb.size() == 0) fail_now("B unexpected result");
                else cmp("B", qb.pop_front(), b_d, b_u);
            end
            if (c_v) begin
                if (qc.size() == 0) fail_now("C unexpected result");
                else cmp("C", qc.pop_front(), c_d, c_u);
            end
            if (d_v) begin
                if (qd.size() == 0) fail_now("D unexpected result");
                else cmp("D", qd.pop_front(), d_d, d_u);
            end
        end
    end

    task automatic drive(input bit s, input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic l, input logic [23:0] bias, input logic ben);
        if (s) begin
            s_v = v; s_i = a; s_k = b; s_l = l; s_b = bias; s_ben = ben;
        end else begin
            u_v = v; u_i = a; u_k = b; u_l = l; u_b = bias; u_ben = ben;
        end
    endtask

    // Present one pair, wait (bounded) for acceptance, then idle the bus.
    task automatic beat(input bit s, input logic [7:0] a, input logic [7:0] b,
                        input logic l, input logic [23:0] bias, input logic ben);
        int n;
        drive(s, 1'b1, a, b, l, bias, ben);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(s ? c_rdy : a_rdy) && n < 100);
        if (n >= 100) fail_now("beat accept timeout");
        @(posedge clk);
        #1;
        drive(s, 1'b0, 8'h0, 8'h0, 1'b0, 24'h0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((qa.size() + qb.size() + qc.size() + qd.size()) != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) fail_now("result drain timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic push_u(input logic [8:0] ea, input logic [8:0] eb);
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    task automatic push_s(input logic [8:0] ec, input logic [8:0] ed);
        qc.push_back(ec);
        qd.push_back(ed);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        o_rdy = 1'b1;
        drive(1'b0, 1'b0, 8'h0, 8'h0, 1'b0, 24'h0, 1'b0);
        drive(1'b1, 1'b0, 8'h0, 8'h0, 1'b0, 24'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset o_TDATA", 32'(a_d), 32'h0);
        chk("reset o_TVALID", 32'(a_v), 32'h0);
        chk("reset o_TUSER", 32'(a_u), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset i_TREADY", 32'(a_rdy), 32'h1);
        @(posedge clk);
        #1;

        // bias 5 + 2*3 + 4*5 + 1*1 = 32, with latency / gap timing checks.
        push_u({1'b0, 8'd32}, {1'b0, 8'd32});
        beat(1'b0, 8'd2, 8'd3, 1'b0, 24'd5, 1'b1);
        beat(1'b0, 8'd4, 8'd5, 1'b0, 24'd5, 1'b1);
        beat(1'b0, 8'd1, 8'd1, 1'b1, 24'd5, 1'b1);
        @(negedge clk);
        chk("cyc1 i_TREADY", 32'(a_rdy), 32'h0);
        chk("cyc1 o_TVALID", 32'(a_v), 32'h0);
        @(negedge clk);
        chk("cyc2 i_TREADY", 32'(a_rdy), 32'h0);
        chk("cyc2 o_TVALID", 32'(a_v), 32'h0);
        @(negedge clk);
        chk("cyc3 i_TREADY", 32'(a_rdy), 32'h0);
        chk("cyc3 o_TVALID", 32'(a_v), 32'h1);
        @(negedge clk);
        chk("cyc4 i_TREADY", 32'(a_rdy), 32'h1);
        chk("cyc4 o_TVALID", 32'(a_v), 32'h0);
        @(posedge clk);
        #1;

        // Chaining: 32 + 256 = 288 -> A clips to 255, B wraps to 32.
        push_u({1'b1, 8'd255}, {1'b0, 8'd32});
        beat(1'b0, 8'd16, 8'd16, 1'b1, 24'd0, 1'b0);
        wait_idle();
        // Chaining: 288 + 100 = 388 -> A clips to 255, B wraps to 132.
        push_u({1'b1, 8'd255}, {1'b0, 8'd132});
        beat(1'b0, 8'd10, 8'd10, 1'b1, 24'd0, 1'b0);
        wait_idle();

        // Single-beat packet: 7 + 3*3 = 16.
        push_u({1'b0, 8'd16}, {1'b0, 8'd16});
        beat(1'b0, 8'd3, 8'd3, 1'b1, 24'd7, 1'b1);
        wait_idle();

        // Bubbles: 1 + 1*2 + 3*4 + 5*6 + 7*8 = 101.
        push_u({1'b0, 8'd101}, {1'b0, 8'd101});
        beat(1'b0, 8'd1, 8'd2, 1'b0, 24'd1, 1'b1);
        idle(1);
        beat(1'b0, 8'd3, 8'd4, 1'b0, 24'd1, 1'b1);
        idle(2);
        beat(1'b0, 8'd5, 8'd6, 1'b0, 24'd1, 1'b1);
        beat(1'b0, 8'd7, 8'd8, 1'b1, 24'd1, 1'b1);
        wait_idle();

        // Backpressure: result 4 held, next packet (1*1 = 1) waiting.
        push_u({1'b0, 8'd4}, {1'b0, 8'd4});
        push_u({1'b0, 8'd1}, {1'b0, 8'd1});
        o_rdy = 1'b0;
        beat(1'b0, 8'd2, 8'd2, 1'b1, 24'd0, 1'b1);
        drive(1'b0, 1'b1, 8'd1, 8'd1, 1'b1, 24'd0, 1'b1);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall i_TREADY", 32'(a_rdy), 32'h0);
            chk("stall o_TVALID", 32'(a_v), 32'h1);
            chk("stall o_TDATA", 32'(a_d), 32'd4);
        end
        @(posedge clk);
        #1;
        o_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release i_TREADY", 32'(a_rdy), 32'h1);
        chk("release o_TVALID", 32'(a_v), 32'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 8'h0, 8'h0, 1'b0, 24'h0, 1'b0);
        wait_idle();

        // Reset in the middle of a 4-beat packet discards it and clears acc.
        beat(1'b0, 8'd1, 8'd1, 1'b0, 24'd9, 1'b1);
        beat(1'b0, 8'd2, 8'd2, 1'b0, 24'd9, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mid reset o_TDATA", 32'(a_d), 32'h0);
        chk("mid reset o_TVALID", 32'(a_v), 32'h0);
        chk("mid reset o_TUSER", 32'(a_u), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("after reset i_TREADY", 32'(a_rdy), 32'h1);
        @(posedge clk);
        #1;
        push_u({1'b0, 8'd1}, {1'b0, 8'd1});
        beat(1'b0, 8'd1, 8'd1, 1'b1, 24'd0, 1'b0);
        wait_idle();

        // Signed: -128*127 + -1*1 = -16257 -> C clips to -128;
        // D: (-16257 + 128) >>> 8 = -64.
        push_s({1'b1, 8'h80}, {1'b0, 8'hC0});
        beat(1'b1, 8'h80, 8'h7F, 1'b0, 24'd0, 1'b1);
        beat(1'b1, 8'hFF, 8'h01, 1'b1, 24'd0, 1'b1);
        wait_idle();
        // Signed: 10 + 5*-3 = -5 -> C -5; D (123 >>> 8) = 0.
        push_s({1'b0, 8'hFB}, {1'b0, 8'h00});
        beat(1'b1, 8'd5, 8'hFD, 1'b1, 24'd10, 1'b1);
        wait_idle();
        // Signed: 40000 + 100*100 = 50000 -> C clips to 127;
        // D (50128 >>> 8) = 195 clips to 127.
        push_s({1'b1, 8'h7F}, {1'b1, 8'h7F});
        beat(1'b1, 8'd100, 8'd100, 1'b1, 24'd40000, 1'b1);
        wait_idle();

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
